imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader_word_assembler.sv | 30 +++
 rtl/imem_loader.sv | 107 ++++++++++
 tb/tb_imem_loader.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: FSM states and stream framing constants shared by imem_loader.
// The S_CHK state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_loader_word_assembler.sv
// imem_word_assembler: collects little-endian stream bytes into 32-bit words.
module imem_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        full
);
    logic [1:0]  cnt;
    logic [23:0] sh;
    // The fourth byte is merged combinationally so the word is ready on its handshake edge.
    assign word = {din, sh};
    assign full = en && cnt == 2'(BYTES_PER_WORD - 1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            sh  <= '0;
        end else if (clr) begin
            cnt <= '0;
            sh  <= '0;
        end else if (en) begin
            cnt <= cnt + 2'd1;
            sh  <= {din, sh[23:8]};
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed byte image into instruction memory while holding the CPU in reset.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_W      = 16,
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int LW = 8 * HDR_BYTES;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_END = S_CHK;
    logic [7:0] csum;
`else
    localparam state_t S_END = S_DONE;
`endif
    state_t        state, nxt;
    logic [7:0]    len_lo;
    logic [LW-1:0] n_new, rem;
    logic          hs, go, asm_en, full, nxt_busy;
    logic [31:0]   word;

    assign hs       = byte_valid && byte_ready;
    assign go       = start && !busy;
    assign asm_en   = hs && state == S_DATA;
    assign n_new    = {byte_data, len_lo};
    assign nxt_busy = !(nxt inside {S_IDLE, S_DONE, S_ERR});

    imem_word_assembler u_asm (
        .clk  (clk),
        .rst  (rst),
        .clr  (go),
        .en   (asm_en),
        .din  (byte_data),
        .word (word),
        .full (full)
    );

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (start) nxt = S_LEN_LO;
            S_LEN_LO: if (hs) nxt = S_LEN_HI;
            S_LEN_HI: if (hs) nxt = 32'(n_new) > DEPTH_WORDS ? S_ERR : n_new == '0 ? S_END : S_DATA;
            S_DATA:   if (full) nxt = S_WRITE;
            S_WRITE:  nxt = rem == LW'(1) ? S_END : S_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK:    if (hs) nxt = byte_data == csum ? S_DONE : S_ERR;
`endif
            default:  nxt = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            byte_ready   <= 1'b0;
            mem_we       <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            cpu_rst_hold <= 1'b1;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            len_lo       <= '0;
            rem          <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            state        <= nxt;
            busy         <= nxt_busy;
            byte_ready   <= nxt_busy && nxt != S_WRITE;
            mem_we       <= nxt == S_WRITE;
            done         <= nxt == S_DONE;
            err          <= nxt == S_ERR;
            cpu_rst_hold <= nxt != S_DONE;
            if (hs && state == S_LEN_LO) len_lo <= byte_data;
            if (hs && state == S_LEN_HI) rem <= n_new;
            if (full) mem_wdata <= word;
            if (go) begin
                mem_addr <= '0;
            end else if (state == S_WRITE) begin
                mem_addr <= mem_addr + ADDR_W'(BYTES_PER_WORD);
                rem      <= rem - LW'(1);
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (go) csum <= '0;
            else if (asm_en) csum <= csum ^ byte_data;
`endif
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader; expected writes are queued as payload is sent.
module tb_imem_loader;
    logic        clk = 0, rst = 1, start = 0, byte_valid = 0;
    logic [7:0]  byte_data = 0;
    logic        byte_ready, mem_we, cpu_rst_hold, busy, done, err;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    int          checks = 0, errors = 0, wr_cnt = 0;
    logic [15:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] pay[$];
    logic [15:0] ea;
    logic [31:0] ed;

    imem_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_rst_hold (cpu_rst_hold),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && mem_we) begin
            wr_cnt++;
            checks++;
            if (exp_addr.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected addr=%h data=%h", mem_addr, mem_wdata);
            end else begin
                ea = exp_addr.pop_front();
                ed = exp_data.pop_front();
                if (mem_addr !== ea || mem_wdata !== ed || byte_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL write got addr=%h data=%h ready=%b exp addr=%h data=%h ready=0",
                             mem_addr, mem_wdata, byte_ready, ea, ed);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic do_start();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        byte_valid = 1;
        byte_data  = b;
        while (!byte_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!byte_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_ready_timeout byte=%h got ready=0 exp 1", b);
        end
        @(negedge clk);
        byte_valid = 0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_session(input int gap);
        logic [7:0]  x = 0;
        logic [15:0] n = 16'(pay.size());
        logic [31:0] w;
        send_byte(n[7:0], gap);
        send_byte(n[15:8], gap);
        foreach (pay[i]) begin
            w = pay[i];
            exp_addr.push_back(16'(4 * i));
            exp_data.push_back(w);
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8], gap);
                x ^= w[8*k +: 8];
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(x, gap);
`endif
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_timeout got busy=1 exp 0", tag);
        end
    endtask

    task automatic test_reset();
        #1 rst = 0;
        #1;
        checks++;
        if ({byte_ready, mem_we, busy, done, err, cpu_rst_hold} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_flags got %b exp 000001", {byte_ready, mem_we, busy, done, err, cpu_rst_hold});
        end
        checks++;
        if (mem_addr !== 16'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem got addr=%h data=%h exp 0 0", mem_addr, mem_wdata);
        end
        @(negedge clk) rst = 1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || byte_ready !== 1'b0 || cpu_rst_hold !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b ready=%b hold=%b exp 0 0 1", busy, byte_ready, cpu_rst_hold);
        end
    endtask

    task automatic test_back_to_back();
        int w0 = wr_cnt;
        logic [7:0]  x = 0;
        logic [31:0] w;
        pay.delete();
        pay.push_back(32'h20); pay.push_back(32'h21); pay.push_back(32'h31); pay.push_back(32'h5);
        do_start();
        checks++;
        if (busy !== 1'b1 || byte_ready !== 1'b1 || cpu_rst_hold !== 1'b1) begin
            errors++;
            $display("FAIL b2b_start got busy=%b ready=%b hold=%b exp 1 1 1", busy, byte_ready, cpu_rst_hold);
        end
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        foreach (pay[i]) begin
            w = pay[i];
            exp_addr.push_back(16'(4 * i));
            exp_data.push_back(w);
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8], 0);
                x ^= w[8*k +: 8];
            end
            checks++;
            if (mem_we !== 1'b1 || byte_ready !== 1'b0 || mem_addr !== 16'(4 * i)) begin
                errors++;
                $display("FAIL b2b_latency word=%0d got we=%b ready=%b addr=%h exp 1 0 %h",
                         i, mem_we, byte_ready, mem_addr, 16'(4 * i));
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(x, 0);
`endif
        wait_idle("b2b");
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || cpu_rst_hold !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done got done=%b err=%b hold=%b exp 1 0 0", done, err, cpu_rst_hold);
        end
        checks++;
        if (wr_cnt - w0 != 4 || exp_addr.size() != 0 || mem_wdata !== 32'h5) begin
            errors++;
            $display("FAIL b2b_writes got n=%0d left=%0d wdata=%h exp 4 0 00000005",
                     wr_cnt - w0, exp_addr.size(), mem_wdata);
        end
    endtask

    task automatic test_zero_len();
        int w0 = wr_cnt;
        pay.delete();
        do_start();
        checks++;
        if (cpu_rst_hold !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL zero_hold_reassert got hold=%b done=%b exp 1 0", cpu_rst_hold, done);
        end
        send_session(0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || wr_cnt != w0) begin
            errors++;
            $display("FAIL zero_len got done=%b busy=%b writes=%0d exp 1 0 0", done, busy, wr_cnt - w0);
        end
    endtask

    task automatic test_overflow();
        int w0 = wr_cnt;
        do_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || done !== 1'b0 || cpu_rst_hold !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL overflow got err=%b done=%b hold=%b busy=%b ready=%b exp 1 0 1 0 0",
                     err, done, cpu_rst_hold, busy, byte_ready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1 || wr_cnt != w0) begin
            errors++;
            $display("FAIL overflow_sticky got err=%b writes=%0d exp 1 0", err, wr_cnt - w0);
        end
        do_start();
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL overflow_clear got err=%b busy=%b exp 0 1", err, busy);
        end
        pay.delete();
        send_session(0);
        wait_idle("overflow");
    endtask

    task automatic test_full_depth();
        int w0 = wr_cnt;
        pay.delete();
        for (int i = 0; i < 256; i++) pay.push_back($urandom);
        do_start();
        send_session(0);
        wait_idle("depth");
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || wr_cnt - w0 != 256 || exp_addr.size() != 0) begin
            errors++;
            $display("FAIL full_depth got done=%b err=%b writes=%0d left=%0d exp 1 0 256 0",
                     done, err, wr_cnt - w0, exp_addr.size());
        end
    endtask

    task automatic test_throttle();
        int w0 = wr_cnt;
        pay.delete();
        pay.push_back(32'h20); pay.push_back(32'h21);
        do_start();
        send_session(1);
        wait_idle("throttle");
        checks++;
        if (done !== 1'b1 || wr_cnt - w0 != 2 || exp_addr.size() != 0) begin
            errors++;
            $display("FAIL throttle got done=%b writes=%0d left=%0d exp 1 2 0", done, wr_cnt - w0, exp_addr.size());
        end
    endtask

    task automatic test_mid_reset();
        int w0 = wr_cnt;
        logic [31:0] w = 32'hA1B2C3D4;
        do_start();
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        exp_addr.push_back(16'h0);
        exp_data.push_back(w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        #2 rst = 0;
        #1;
        checks++;
        if ({byte_ready, mem_we, busy, done, err, cpu_rst_hold} !== 6'b000001 ||
            mem_addr !== 16'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_async got flags=%b addr=%h data=%h exp 000001 0000 00000000",
                     {byte_ready, mem_we, busy, done, err, cpu_rst_hold}, mem_addr, mem_wdata);
        end
        @(negedge clk) rst = 1;
        repeat (3) @(negedge clk);
        checks++;
        if (wr_cnt - w0 != 1 || exp_addr.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_writes got writes=%0d left=%0d busy=%b exp 1 0 0",
                     wr_cnt - w0, exp_addr.size(), busy);
        end
        pay.delete();
        pay.push_back(32'hCAFEF00D);
        do_start();
        send_session(0);
        wait_idle("after_reset");
        checks++;
        if (done !== 1'b1 || mem_wdata !== 32'hCAFEF00D || exp_addr.size() != 0) begin
            errors++;
            $display("FAIL partial_discard got done=%b wdata=%h left=%0d exp 1 cafef00d 0",
                     done, mem_wdata, exp_addr.size());
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [31:0] w = 32'h44332211;
        for (int c = 0; c < 2; c++) begin
            do_start();
            send_byte(8'h01, 0);
            send_byte(8'h00, 0);
            exp_addr.push_back(16'h0);
            exp_data.push_back(w);
            for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 0);
            send_byte(c == 0 ? 8'h44 : 8'h45, 0);
            wait_idle("checksum");
            checks++;
            if (done !== (c == 0) || err !== (c != 0) || cpu_rst_hold !== (c != 0)) begin
                errors++;
                $display("FAIL checksum_%0d got done=%b err=%b hold=%b exp %b %b %b",
                         c, done, err, cpu_rst_hold, c == 0, c != 0, c != 0);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_zero_len();
        test_overflow();
        test_full_depth();
        test_throttle();
        test_mid_reset();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
